reflet_mem_arbiter: RTL and testbench

REFLET_MEM_ARBITER -- requirements
Module: reflet_mem_arbiter

---
 rtl/reflet_mem_arbiter.sv | 101 ++++++++++
 tb/tb_reflet_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_mem_arbiter.sv
// Two-master round-robin arbiter in front of one single-port synchronous memory.
// Each grant runs IDLE -> ACCESS -> ACK, so at most one transaction completes every three cycles.
module reflet_mem_arbiter #(
  parameter int unsigned wordsize = 16,
  parameter int unsigned addrSize = 15
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                m0_req,
  input  logic [addrSize-1:0] m0_addr,
  input  logic [wordsize-1:0] m0_wdata,
  input  logic                m0_we,
  output logic                m0_ack,
  output logic [wordsize-1:0] m0_rdata,

  input  logic                m1_req,
  input  logic [addrSize-1:0] m1_addr,
  input  logic [wordsize-1:0] m1_wdata,
  input  logic                m1_we,
  output logic                m1_ack,
  output logic [wordsize-1:0] m1_rdata,

  output logic                mem_enable,
  output logic [addrSize-1:0] mem_addr,
  output logic [wordsize-1:0] mem_data_out,
  output logic                mem_write_en,
  input  logic [wordsize-1:0] mem_data_in
);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e state_q;
  logic   owner_q;
  logic   last_owner_q;
  logic   we_q;
  logic   winner;

  // On a tie the master that was not served last wins.
  always_comb begin
    if (m0_req && m1_req) begin
      winner = ~last_owner_q;
    end else begin
      winner = m1_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      mem_enable   <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
    end else begin
      // Memory strobes and acks are single-cycle pulses; default them low.
      mem_enable   <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (m0_req || m1_req) begin
            owner_q      <= winner;
            last_owner_q <= winner;
            we_q         <= winner ? m1_we : m0_we;
            mem_enable   <= 1'b1;
            mem_write_en <= winner ? m1_we : m0_we;
            mem_addr     <= winner ? m1_addr : m0_addr;
            mem_data_out <= winner ? m1_wdata : m0_wdata;
            state_q      <= StAccess;
          end
        end
        StAccess: begin
          m0_ack  <= ~owner_q;
          m1_ack  <= owner_q;
          state_q <= StAck;
        end
        StAck: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Read data is forwarded straight from memory so it lines up with the ack cycle;
  // zero otherwise so both masters' buses can be OR-combined.
  assign m0_rdata = (m0_ack && !we_q) ? mem_data_in : '0;
  assign m1_rdata = (m1_ack && !we_q) ? mem_data_in : '0;

endmodule

// File: tb/tb_reflet_mem_arbiter.sv
// Scoreboard bench for reflet_mem_arbiter: a transaction-level model predicts memory accesses
// and acks per cycle; a negedge monitor pops and compares them against the DUT.
module tb_reflet_mem_arbiter;

  localparam int unsigned W   = 16;
  localparam int unsigned A   = 15;
  localparam int unsigned TBL = 4096;

  typedef logic [W-1:0] word_t;
  typedef logic [A-1:0] addr_t;

  typedef struct {
    int    cyc;
    logic  we;
    addr_t addr;
    word_t wdata;
  } acc_t;

  typedef struct {
    int    cyc;
    int    who;
    word_t rdata;
  } ack_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  m0_ack, m1_ack, mem_enable, mem_write_en;
  word_t m0_rdata, m1_rdata, mem_data_out, mem_data_in;
  addr_t mem_addr;

  logic  req   [2];
  logic  we    [2];
  addr_t addr  [2];
  word_t wdata [2];
  bit    busy  [2];
  int    ack_cyc [2];

  acc_t  acc_q[$];
  ack_t  ack_q[$];
  word_t rd_tbl [TBL];

  int cyc;
  int checks;
  int errors;
  int next_idle;
  int last_owner;
  bit mon_en;
  bit clr_pending;
  bit rand_new;
  bit rand_drop;
  bit cont;

  always #5 clk = ~clk;

  reflet_mem_arbiter #(
    .wordsize (W),
    .addrSize (A)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .m0_req       (req[0]),
    .m0_addr      (addr[0]),
    .m0_wdata     (wdata[0]),
    .m0_we        (we[0]),
    .m0_ack       (m0_ack),
    .m0_rdata     (m0_rdata),
    .m1_req       (req[1]),
    .m1_addr      (addr[1]),
    .m1_wdata     (wdata[1]),
    .m1_we        (we[1]),
    .m1_ack       (m1_ack),
    .m1_rdata     (m1_rdata),
    .mem_enable   (mem_enable),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_write_en (mem_write_en),
    .mem_data_in  (mem_data_in)
  );

  // Reference: one grant per free slot, round-robin on ties, access one cycle later, ack two.
  task automatic model_eval();
    int w;
    if (rst) begin
      while (acc_q.size() > 0 && acc_q[$].cyc > cyc) void'(acc_q.pop_back());
      while (ack_q.size() > 0 && ack_q[$].cyc > cyc) void'(ack_q.pop_back());
      next_idle   = cyc + 1;
      last_owner  = 1;
      clr_pending = 1'b1;
    end else if (cyc >= next_idle && (req[0] || req[1])) begin
      w = (req[0] && req[1]) ? 1 - last_owner : (req[1] ? 1 : 0);
      acc_q.push_back('{cyc + 1, we[w], addr[w], wdata[w]});
      ack_q.push_back('{cyc + 2, w, we[w] ? word_t'(0) : rd_tbl[(cyc + 2) % TBL]});
      busy[w]    = 1'b1;
      ack_cyc[w] = cyc + 2;
      last_owner = w;
      next_idle  = cyc + 3;
    end
  endtask

  task automatic new_req(input int m, input logic w, input addr_t a, input word_t d);
    req[m]   = 1'b1;
    we[m]    = w;
    addr[m]  = a;
    wdata[m] = d;
  endtask

  task automatic update_masters();
    for (int m = 0; m < 2; m++) begin
      if (clr_pending) begin
        req[m]  = 1'b0;
        busy[m] = 1'b0;
      end
      if (busy[m] && cyc > ack_cyc[m]) begin
        busy[m] = 1'b0;
        req[m]  = 1'b0;
      end
      if (busy[m] && req[m] && rand_drop && $urandom_range(0, 3) == 0) req[m] = 1'b0;
      if (!req[m] && !busy[m] && (cont || (rand_new && $urandom_range(0, 2) == 0)))
        new_req(m, logic'($urandom_range(0, 1)), addr_t'($urandom()), word_t'($urandom()));
    end
    clr_pending = 1'b0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    #1;
    cyc++;
    mem_data_in = rd_tbl[cyc % TBL];
    update_masters();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    acc_t  a;
    ack_t  k;
    logic  e_en, e_we, e_a0, e_a1;
    addr_t e_addr;
    word_t e_wd, e_r0, e_r1;
    if (mon_en) begin
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
      if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
        a = acc_q.pop_front();
        e_en = 1'b1; e_we = a.we; e_addr = a.addr; e_wd = a.wdata;
      end
      checks++;
      if ({mem_enable, mem_write_en, mem_addr, mem_data_out} !== {e_en, e_we, e_addr, e_wd}) begin
        errors++;
        $display("FAIL mem_port cyc %0d: got en=%b we=%b addr=%h data=%h, want en=%b we=%b addr=%h data=%h",
                 cyc, mem_enable, mem_write_en, mem_addr, mem_data_out, e_en, e_we, e_addr, e_wd);
      end
      e_a0 = 1'b0; e_a1 = 1'b0; e_r0 = '0; e_r1 = '0;
      if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
        k = ack_q.pop_front();
        if (k.who == 0) begin e_a0 = 1'b1; e_r0 = k.rdata; end
        else begin e_a1 = 1'b1; e_r1 = k.rdata; end
      end
      checks++;
      if ({m0_ack, m0_rdata, m1_ack, m1_rdata} !== {e_a0, e_r0, e_a1, e_r1}) begin
        errors++;
        $display("FAIL ack_port cyc %0d: got ack0=%b rd0=%h ack1=%b rd1=%h, want ack0=%b rd0=%h ack1=%b rd1=%h",
                 cyc, m0_ack, m0_rdata, m1_ack, m1_rdata, e_a0, e_r0, e_a1, e_r1);
      end
    end
  end

  initial begin
    cyc = 0; checks = 0; errors = 0; next_idle = 0; last_owner = 1;
    mon_en = 1'b0; clr_pending = 1'b0; rand_new = 1'b0; rand_drop = 1'b0; cont = 1'b0;
    for (int i = 0; i < int'(TBL); i++) rd_tbl[i] = word_t'($urandom());
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0; busy[m] = 1'b0; ack_cyc[m] = 0;
    end
    mem_data_in = rd_tbl[0];
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    run(2);

    // Lone m0 read of 0x0010 returning 0xBEEF.
    rd_tbl[(cyc + 2) % TBL] = 16'hBEEF;
    new_req(0, 1'b0, 15'h0010, 16'h0000);
    run(5);
    // Lone m1 write of 0x1234 to 0x0020.
    new_req(1, 1'b1, 15'h0020, 16'h1234);
    run(5);
    // m0 served last, then a tie must go to m1 first.
    new_req(0, 1'b1, 15'h0033, 16'h5A5A);
    run(4);
    new_req(0, 1'b0, 15'h0044, 16'h0000);
    new_req(1, 1'b0, 15'h0055, 16'h0000);
    run(8);

    // Both masters requesting continuously after reset: strict alternation starting with m0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cont = 1'b1;
    run(13);
    cont = 1'b0;
    run(6);

    // Reset during the ACCESS cycle of an m0 read aborts it; first tie afterwards goes to m0.
    new_req(0, 1'b0, 15'h0066, 16'h0000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    new_req(0, 1'b1, 15'h0077, 16'h1111);
    new_req(1, 1'b1, 15'h0088, 16'h2222);
    run(8);

    // One-cycle m0 pulse still completes exactly once.
    new_req(0, 1'b0, 15'h0099, 16'h0000);
    tick();
    req[0] = 1'b0;
    run(6);

    // Randomised traffic with occasional resets and post-grant request drops.
    rand_new  = 1'b1;
    rand_drop = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    rand_new  = 1'b0;
    rand_drop = 1'b0;
    run(10);

    checks++;
    if (acc_q.size() != 0 || ack_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d accesses and %0d acks outstanding, want 0 and 0",
               acc_q.size(), ack_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
